bb_share_arb: RTL

Round-robin issue controller that shares one fixed-latency delay datapath (a `bb` instance, or any `LAT`-cycle pipeline) among `NREQ` requesters. It arbitrates valid/ready requests and launches the winning word into the datapath. A matching internal valid/ID shift line tracks each word, and returned results land in an internal output FIFO tagged with the requester ID. A credit counter guarantees the FIFO can never overflow under downstream backpressure.

---
 rtl/bb_share_arb_if.sv | 25 ++
 rtl/bb_share_arb.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bb_share_arb_if.sv
// Requester and output-FIFO handshake bundle for bb_share_arb.
// The slave side is the arbiter; the master side is the surrounding logic.
interface bb_share_arb_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [IDW-1:0]        out_id;
    logic [WIDTH-1:0]      out_data;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_id, out_data
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_id, out_data
    );
endinterface

// File: rtl/bb_share_arb.sv
// Round-robin issue controller sharing one LAT-cycle datapath among NREQ requesters.
// Optional macro BB_SHARE_ARB_STATS_EN adds a saturating stall_cnt output.
module bb_share_arb #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int LAT     = 4,
    parameter int CREDITS = 8,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic             clock,
    input  logic             reset,
    bb_share_arb_if.slave    bus,
    output logic             pipe_valid_o,
    output logic [WIDTH-1:0] pipe_data_o,
    input  logic [WIDTH-1:0] pipe_data_i
`ifdef BB_SHARE_ARB_STATS_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);
    localparam int OCCW = $clog2(CREDITS + 1);
    localparam int PTRW = $clog2(CREDITS);
    localparam int EW   = IDW + WIDTH;

    logic [IDW-1:0]   last_q, last_d;
    logic [OCCW-1:0]  occ_q, occ_d;
    logic             pipe_valid_q, pipe_valid_d;
    logic [WIDTH-1:0] pipe_data_q, pipe_data_d;
    logic [IDW-1:0]   launch_id_q, launch_id_d;
    logic [LAT-1:0]   sv_q, sv_d;
    logic [IDW-1:0]   sid_q [LAT];
    logic [IDW-1:0]   sid_d [LAT];
    logic [PTRW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [OCCW-1:0]  cnt_q, cnt_d;
    logic [EW-1:0]    mem_q [CREDITS];

    logic             grant_vld;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   cand_idx;
    int               cand;
    logic             credit_ok;
    logic             issue;
    logic             pop;
    logic             push;
    logic [EW-1:0]    head;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(CREDITS - 1)) ? '0 : p + 1'b1;
    endfunction

    // First valid requester searching upward from last+1, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand     = (int'(last_q) + i) % NREQ;
            cand_idx = IDW'(cand);
            if (!grant_vld && bus.req_valid[cand_idx]) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    assign credit_ok     = (occ_q < OCCW'(CREDITS));
    assign issue         = grant_vld & credit_ok;
    assign bus.req_ready = issue ? (NREQ'(1) << grant_idx) : '0;
    assign pop           = bus.out_valid & bus.out_ready;
    assign push          = sv_q[LAT-1];

    // Pointer, credit and launch register next-state.
    always_comb begin
        last_d       = issue ? grant_idx : last_q;
        occ_d        = occ_q;
        if (issue && !pop) occ_d = occ_q + 1'b1;
        else if (!issue && pop) occ_d = occ_q - 1'b1;
        pipe_valid_d = issue;
        pipe_data_d  = pipe_data_q;
        launch_id_d  = launch_id_q;
        if (issue) begin
            pipe_data_d = bus.req_data[grant_idx*WIDTH +: WIDTH];
            launch_id_d = grant_idx;
        end
    end

    // Valid/ID shift line that mirrors the external datapath delay.
    always_comb begin
        sv_d     = '0;
        sv_d[0]  = pipe_valid_q;
        sid_d[0] = launch_id_q;
        for (int k = 1; k < LAT; k++) begin
            sv_d[k]  = sv_q[k-1];
            sid_d[k] = sid_q[k-1];
        end
    end

    // Output FIFO pointers and fill level.
    always_comb begin
        wr_d  = push ? ptr_inc(wr_q) : wr_q;
        rd_d  = pop ? ptr_inc(rd_q) : rd_q;
        cnt_d = cnt_q;
        if (push && !pop) cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;
    end

    // State registers; reset drops all in-flight and queued words.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q       <= IDW'(NREQ - 1);
            occ_q        <= '0;
            pipe_valid_q <= 1'b0;
            pipe_data_q  <= '0;
            launch_id_q  <= '0;
            sv_q         <= '0;
            for (int k = 0; k < LAT; k++) sid_q[k] <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
        end else begin
            last_q       <= last_d;
            occ_q        <= occ_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_data_q  <= pipe_data_d;
            launch_id_q  <= launch_id_d;
            sv_q         <= sv_d;
            for (int k = 0; k < LAT; k++) sid_q[k] <= sid_d[k];
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
        end
    end

    // FIFO storage; credits guarantee a free slot on every push.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_q] <= {sid_q[LAT-1], pipe_data_i};
    end

    assign head          = mem_q[rd_q];
    assign bus.out_valid = (cnt_q != '0);
    assign bus.out_id    = bus.out_valid ? head[EW-1:WIDTH] : '0;
    assign bus.out_data  = bus.out_valid ? head[WIDTH-1:0] : '0;
    assign pipe_valid_o  = pipe_valid_q;
    assign pipe_data_o   = pipe_data_q;

`ifdef BB_SHARE_ARB_STATS_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of cycles with demand but no credit.
    always_comb begin
        stall_d = stall_q;
        if ((|bus.req_valid) && !credit_ok && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    // Stall counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif
endmodule
